nn_polar_ssgen_8channel: RTL and testbench

NN_POLAR_SSGEN_8CHANNEL -- requirements
Module: nn_polar_ssgen_8channel

---
 rtl/nn_polar_ssgen_8channel.sv | 119 +++++++++++
 tb/tb_nn_polar_ssgen_8channel.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nn_polar_ssgen_8channel.sv
// Eight-channel polar stochastic stream generator.
// Each channel compares a private 8-bit maximal-length LFSR against a captured
// magnitude to emit one unary-weighted bit per enabled cycle; signs ride along.
// Optional build macro: NN_SSGEN_RELOAD_EN -- reseed every LFSR on each accepted
// START so identical inputs yield identical streams.
module nn_polar_ssgen_8channel #(
  parameter int unsigned N     = 8,
  parameter int unsigned N_LEN = 10,
  parameter logic [7:0]  SEED  = 8'hA8
) (
  input  logic               CLK,
  input  logic               INIT,
  input  logic               EN,
  input  logic               START,
  input  logic [8*N-1:0]     MAG_IN,
  input  logic [7:0]         SIGN_IN,
  input  logic [N_LEN-1:0]   LEN,
  output logic [7:0]         SS_OUT,
  output logic [7:0]         SIGN_OUT,
  output logic               BUSY,
  output logic               DONE
);

  localparam int unsigned NCH = 8;
  localparam int unsigned LW  = 8;
  localparam int unsigned CW  = (N > LW) ? N : LW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [8*N-1:0]     mag_q;
  logic [N_LEN-1:0]   len_q;
  logic [N_LEN-1:0]   cnt;
  logic [LW-1:0]      lfsr      [NCH];
  logic [LW-1:0]      lfsr_step [NCH];
  logic [LW-1:0]      lfsr_seed [NCH];
  logic [NCH-1:0]     ss_bits;
  logic [NCH-1:0]     ss_nxt;
  logic [NCH-1:0]     sign_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               accept;
  logic               advance;

  // Per-channel seed, LFSR successor (x^8+x^6+x^5+x^4+1) and comparator bit
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lfsr_seed[i] = {SEED[7:3], 3'(i)};
      lfsr_step[i] = {lfsr[i][6:0], lfsr[i][7] ^ lfsr[i][5] ^ lfsr[i][4] ^ lfsr[i][3]};
      ss_bits[i]   = (CW'(lfsr[i]) <= CW'(mag_q[N*i +: N]));
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (INIT) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; an empty burst (LEN=0) leaves RUN immediately
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (START) state_nxt = S_RUN;
      S_RUN: begin
        if (len_q == '0)                                state_nxt = S_DONE;
        else if (EN && (cnt == (len_q - N_LEN'(1))))    state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/next-register values; SS_OUT holds while stalled and clears outside RUN
  always_comb begin
    accept   = (state == S_IDLE) && START;
    advance  = (state == S_RUN) && EN && (len_q != '0);
    ss_nxt   = '0;
    if (advance)               ss_nxt = ss_bits;
    else if (state == S_RUN)   ss_nxt = SS_OUT;
    sign_nxt = accept ? SIGN_IN : SIGN_OUT;
    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
  end

  // Datapath: shadow capture, cycle counter, LFSRs and registered outputs
  always_ff @(posedge CLK) begin
    if (INIT) begin
      mag_q    <= '0;
      len_q    <= '0;
      cnt      <= '0;
      SS_OUT   <= '0;
      SIGN_OUT <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      for (int i = 0; i < NCH; i++) lfsr[i] <= lfsr_seed[i];
    end else begin
      if (accept) begin
        mag_q <= MAG_IN;
        len_q <= LEN;
        cnt   <= '0;
      end else if (advance) begin
        cnt <= cnt + N_LEN'(1);
      end
      SS_OUT   <= ss_nxt;
      SIGN_OUT <= sign_nxt;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (advance) lfsr[i] <= lfsr_step[i];
`ifdef NN_SSGEN_RELOAD_EN
        else if (accept) lfsr[i] <= lfsr_seed[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_nn_polar_ssgen_8channel.sv
// Self-checking bench for nn_polar_ssgen_8channel: table of bursts plus
// hand-written sequences for abort and back-to-back stream comparison.
module tb_nn_polar_ssgen_8channel;

  logic        CLK = 1'b0;
  logic        INIT, EN, START;
  logic [63:0] MAG_IN;
  logic [7:0]  SIGN_IN;
  logic [9:0]  LEN;
  logic [7:0]  SS_OUT, SIGN_OUT;
  logic        BUSY, DONE;

  int checks = 0;
  int errors = 0;

  nn_polar_ssgen_8channel #(.N(8), .N_LEN(10), .SEED(8'hA8)) dut (
    .CLK(CLK), .INIT(INIT), .EN(EN), .START(START), .MAG_IN(MAG_IN),
    .SIGN_IN(SIGN_IN), .LEN(LEN), .SS_OUT(SS_OUT), .SIGN_OUT(SIGN_OUT),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] mag;
    logic [7:0]  sgn;
    logic [9:0]  len;
    int          stall_at;
    int          stall_len;
    int          exp_edges;
    bit          chk_ones;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  m_lfsr[8];
  logic [7:0]  seq_last[256];
  logic [7:0]  seq_a[256];
  int          ones[8];
  int          bits_got;
  int          edges_got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_seed();
    for (int i = 0; i < 8; i++) m_lfsr[i] = 8'hA8 | 8'(i);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full burst from IDLE: capture, stream (with optional stall), DONE, return to IDLE
  task automatic run_burst(input logic [63:0] mag, input logic [7:0] sgn, input logic [9:0] len,
                           input int stall_at, input int stall_len);
    logic [7:0] exp_ss;
    logic [7:0] prev_ss;
    logic       en_now;
    logic       done_seen;
    int         stalled;
    for (int i = 0; i < 8; i++) ones[i] = 0;
    MAG_IN = mag; SIGN_IN = sgn; LEN = len; START = 1'b1; EN = 1'b0;
    tick();
`ifdef NN_SSGEN_RELOAD_EN
    model_seed();
`endif
    START = 1'b0; MAG_IN = ~mag; SIGN_IN = 8'h00; LEN = 10'd3;
    chk("capture_busy", 64'(BUSY), 64'd1);
    chk("capture_sign", 64'(SIGN_OUT), 64'(sgn));
    chk("capture_ss_zero", 64'(SS_OUT), 64'd0);
    bits_got = 0; edges_got = 0; stalled = 0; done_seen = 1'b0; prev_ss = SS_OUT;
    while (!done_seen && edges_got < 2000) begin
      en_now = !((bits_got == stall_at) && (stalled < stall_len));
      EN = en_now;
      tick();
      edges_got++;
      if (en_now && len != 10'd0) begin
        for (int i = 0; i < 8; i++) begin
          exp_ss[i] = (m_lfsr[i] <= mag[8*i +: 8]);
          m_lfsr[i] = {m_lfsr[i][6:0], m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
          ones[i] += int'(SS_OUT[i]);
        end
        chk("ss_bit", 64'(SS_OUT), 64'(exp_ss));
        seq_last[bits_got] = SS_OUT;
        bits_got++;
      end else begin
        if (!en_now) stalled++;
        chk("ss_frozen", 64'(SS_OUT), 64'(prev_ss));
      end
      prev_ss = SS_OUT;
      chk("sign_hold", 64'(SIGN_OUT), 64'(sgn));
      if (DONE) begin
        done_seen = 1'b1;
        chk("busy_in_done", 64'(BUSY), 64'd0);
      end else begin
        chk("busy_in_run", 64'(BUSY), 64'd1);
      end
    end
    chk("done_reached", 64'(done_seen), 64'd1);
    // START during the DONE cycle must be ignored
    START = 1'b1; EN = 1'b0; MAG_IN = '1; LEN = 10'd5;
    tick();
    START = 1'b0;
    chk("idle_busy", 64'(BUSY), 64'd0);
    chk("idle_done", 64'(DONE), 64'd0);
    chk("idle_ss", 64'(SS_OUT), 64'd0);
    chk("idle_sign", 64'(SIGN_OUT), 64'(sgn));
    tick();
    chk("start_in_done_ignored", 64'(BUSY), 64'd0);
  endtask

  initial begin
    int diff;
    int pulses;
    vecs[0] = '{64'h407FFE020180FF00, 8'hA5, 10'd255, -1, 0,   255, 1'b1};
    vecs[1] = '{64'h8877665544332211, 8'h3C, 10'd255, -1, 0,   255, 1'b1};
    vecs[2] = '{64'h5555555555555555, 8'h5A, 10'd100, 40, 10,  110, 1'b0};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 10'd0,   -1, 0,   1,   1'b0};
    vecs[4] = '{64'hC8C8C8C8C8C8C8C8, 8'h00, 10'd1,   -1, 0,   1,   1'b0};
    vecs[5] = '{64'hF50A9C63FC0300FF, 8'hC3, 10'd255, 100, 5, 260, 1'b1};

    INIT = 1'b1; EN = 1'b1; START = 1'b1; MAG_IN = '1; SIGN_IN = 8'hFF; LEN = 10'd7;
    tick(); tick();
    model_seed();
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    chk("reset_ss", 64'(SS_OUT), 64'd0);
    chk("reset_sign", 64'(SIGN_OUT), 64'd0);
    INIT = 1'b0; START = 1'b0;
    tick();
    chk("idle_stays_idle", 64'(BUSY), 64'd0);

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].mag, vecs[v].sgn, vecs[v].len, vecs[v].stall_at, vecs[v].stall_len);
      chk("burst_bits", 64'(bits_got), 64'(vecs[v].len));
      chk("burst_done_edge", 64'(edges_got), 64'(vecs[v].exp_edges));
      if (vecs[v].chk_ones)
        for (int i = 0; i < 8; i++)
          chk("ones_count", 64'(ones[i]), 64'(vecs[v].mag[8*i +: 8]));
    end

    // Back-to-back identical bursts
    run_burst(64'h5555555555555555, 8'h11, 10'd64, -1, 0);
    for (int k = 0; k < 64; k++) seq_a[k] = seq_last[k];
    run_burst(64'h5555555555555555, 8'h11, 10'd64, -1, 0);
    diff = 0;
    for (int k = 0; k < 64; k++) if (seq_a[k] != seq_last[k]) diff++;
`ifdef NN_SSGEN_RELOAD_EN
    chk("repeat_identical", 64'(diff), 64'd0);
`else
    chk("repeat_differs", 64'(diff != 0), 64'd1);
`endif

    // INIT aborts a burst at RUN cycle 50
    MAG_IN = 64'hFFFFFFFFFFFFFFFF; SIGN_IN = 8'h96; LEN = 10'd100; START = 1'b1; EN = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 50; k++) tick();
    chk("pre_abort_busy", 64'(BUSY), 64'd1);
    chk("pre_abort_ss", 64'(SS_OUT), 64'hFF);
    INIT = 1'b1; START = 1'b1;
    tick();
    INIT = 1'b0; START = 1'b0;
    model_seed();
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    chk("abort_ss", 64'(SS_OUT), 64'd0);
    chk("abort_sign", 64'(SIGN_OUT), 64'd0);
    pulses = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      pulses += int'(DONE) + int'(BUSY);
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    // Streams after INIT restart from the seeds
    run_burst(64'h8040201008040201, 8'h7E, 10'd20, -1, 0);
    chk("post_init_bits", 64'(bits_got), 64'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
